// File: rtl/ycr_arb_pkg.sv
// rtl/ycr_arb_pkg.sv - shared constants and types for the arbiter request mux
package ycr_arb_pkg;

    localparam int N_REQ = 4;

    localparam logic [2:0] GNT_NONE = 3'b111;

    localparam logic [1:0] RESP_IDLE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_WAIT_RESP
    } state_e;

endpackage

// File: rtl/ycr_req_sel.sv
// rtl/ycr_req_sel.sv - combinational grant-indexed request field mux
module ycr_req_sel
    import ycr_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic [2:0]          arb_gnt,
    input  logic [N_REQ-1:0]    core_req,
    input  logic [N_REQ-1:0]    core_cmd,
    input  logic [2*N_REQ-1:0]  core_width,
    input  logic [N_REQ*AW-1:0] core_addr,
    input  logic [N_REQ*DW-1:0] core_wdata,
    output logic                sel_req,
    output logic                sel_cmd,
    output logic [1:0]          sel_width,
    output logic [AW-1:0]       sel_addr,
    output logic [DW-1:0]       sel_wdata
);

    logic       gnt_vld;
    logic [1:0] idx;

    assign gnt_vld = (arb_gnt != GNT_NONE) && !arb_gnt[2];
    assign idx     = arb_gnt[1:0];

    always_comb begin
        sel_req   = 1'b0;
        sel_cmd   = 1'b0;
        sel_width = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt_vld) begin
            sel_req   = core_req[idx];
            sel_cmd   = core_cmd[idx];
            sel_width = core_width[{idx, 1'b0} +: 2];
            sel_addr  = core_addr[int'(idx) * AW +: AW];
            sel_wdata = core_wdata[int'(idx) * DW +: DW];
        end
    end

endmodule

// File: rtl/ycr_arb_req_mux.sv
// rtl/ycr_arb_req_mux.sv - forwards granted request to memory and routes the response back
module ycr_arb_req_mux
    import ycr_arb_pkg::*;
#(
    parameter int               AW      = 32,
    parameter int               DW      = 32,
    parameter int               TMO_W   = 8,
    parameter logic [TMO_W-1:0] TMO_CYC = 8'd200
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [2:0]          arb_gnt,
    output logic                arb_req_ack,
    output logic                arb_lack,
    input  logic [N_REQ-1:0]    core_req,
    input  logic [N_REQ-1:0]    core_cmd,
    input  logic [2*N_REQ-1:0]  core_width,
    input  logic [N_REQ*AW-1:0] core_addr,
    input  logic [N_REQ*DW-1:0] core_wdata,
    output logic [N_REQ-1:0]    core_req_ack,
    output logic [DW-1:0]       core_rdata,
    output logic [2*N_REQ-1:0]  core_resp,
    output logic                mem_req,
    input  logic                mem_req_ack,
    output logic                mem_cmd,
    output logic [1:0]          mem_width,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    input  logic [1:0]          mem_resp
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - 1'b1;

    state_e               state_q, state_d;
    logic [1:0]           resp_id_q, resp_id_d;
    logic [TMO_W-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [2*N_REQ-1:0]   resp_q, resp_d;

    logic                 sel_req;
    logic                 sel_cmd;
    logic [1:0]           sel_width;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;

    ycr_req_sel #(
        .AW (AW),
        .DW (DW)
    ) u_req_sel (
        .arb_gnt    (arb_gnt),
        .core_req   (core_req),
        .core_cmd   (core_cmd),
        .core_width (core_width),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .sel_req    (sel_req),
        .sel_cmd    (sel_cmd),
        .sel_width  (sel_width),
        .sel_addr   (sel_addr),
        .sel_wdata  (sel_wdata)
    );

    always_comb begin
        state_d      = state_q;
        resp_id_d    = resp_id_q;
        cnt_d        = cnt_q;
        rdata_d      = '0;
        resp_d       = '0;
        mem_req      = 1'b0;
        mem_cmd      = 1'b0;
        mem_width    = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        arb_req_ack  = 1'b0;
        arb_lack     = 1'b0;
        core_req_ack = '0;

        case (state_q)
            S_IDLE: begin
                // rstn gating keeps the combinational request path quiet during reset
                if (rstn) begin
                    mem_req   = sel_req;
                    mem_cmd   = sel_cmd;
                    mem_width = sel_width;
                    mem_addr  = sel_addr;
                    mem_wdata = sel_wdata;
                    if (sel_req && mem_req_ack) begin
                        arb_req_ack               = 1'b1;
                        core_req_ack[arb_gnt[1:0]] = 1'b1;
                        resp_id_d                 = arb_gnt[1:0];
                        cnt_d                     = '0;
                        state_d                   = S_WAIT_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_resp != RESP_IDLE) begin
                    arb_lack                     = 1'b1;
                    rdata_d                      = mem_rdata;
                    resp_d[{resp_id_q, 1'b0} +: 2] = (mem_resp == RESP_OK) ? RESP_OK : RESP_ERR;
                    state_d                      = S_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    arb_lack                     = 1'b1;
                    resp_d[{resp_id_q, 1'b0} +: 2] = RESP_ERR;
                    state_d                      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            resp_id_q <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            resp_id_q <= resp_id_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign core_rdata = rdata_q;
    assign core_resp  = resp_q;

endmodule

// File: tb/tb_ycr_arb_req_mux.sv
// tb/tb_ycr_arb_req_mux.sv - directed self-checking bench for ycr_arb_req_mux
module tb_ycr_arb_req_mux;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [2:0]    arb_gnt;
    logic          arb_req_ack;
    logic          arb_lack;
    logic [3:0]    core_req;
    logic [3:0]    core_cmd;
    logic [7:0]    core_width;
    logic [4*AW-1:0] core_addr;
    logic [4*DW-1:0] core_wdata;
    logic [3:0]    core_req_ack;
    logic [DW-1:0] core_rdata;
    logic [7:0]    core_resp;
    logic          mem_req;
    logic          mem_req_ack;
    logic          mem_cmd;
    logic [1:0]    mem_width;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    mem_resp;

    int n_tests = 0;
    int n_fail  = 0;
    int early_lack;

    ycr_arb_req_mux dut (
        .clk          (clk),
        .rstn         (rstn),
        .arb_gnt      (arb_gnt),
        .arb_req_ack  (arb_req_ack),
        .arb_lack     (arb_lack),
        .core_req     (core_req),
        .core_cmd     (core_cmd),
        .core_width   (core_width),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_req_ack (core_req_ack),
        .core_rdata   (core_rdata),
        .core_resp    (core_resp),
        .mem_req      (mem_req),
        .mem_req_ack  (mem_req_ack),
        .mem_cmd      (mem_cmd),
        .mem_width    (mem_width),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int id, input logic cmd, input logic [1:0] w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_cmd[id]          = cmd;
        core_width[id*2 +: 2] = w;
        core_addr[id*AW +: AW] = a;
        core_wdata[id*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        arb_gnt     = 3'b111;
        core_req    = '0;
        mem_req_ack = 1'b0;
        mem_resp    = 2'b00;
        mem_rdata   = '0;
    endtask

    initial begin
        rstn       = 1'b0;
        core_cmd   = '0;
        core_width = '0;
        core_addr  = '0;
        core_wdata = '0;
        idle_inputs();
        set_core(0, 1'b0, 2'b10, 32'h0000_0100, 32'h1111_1111);
        set_core(1, 1'b1, 2'b01, 32'h0000_2004, 32'hCAFE_F00D);
        set_core(2, 1'b0, 2'b10, 32'h0000_1000, 32'h2222_2222);
        set_core(3, 1'b0, 2'b00, 32'h0000_3003, 32'h3333_3333);
        repeat (2) step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_core_resp", core_resp, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_lack", arb_lack, 0);
        rstn = 1'b1;
        step();

        // grant 2 read, immediate accept, response after 3 cycles
        arb_gnt = 3'd2; core_req = 4'b0100; mem_req_ack = 1'b1;
        #1;
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h1000);
        chk("t1_arb_req_ack", arb_req_ack, 1);
        chk("t1_core_req_ack", core_req_ack, 4'b0100);
        step();
        idle_inputs();
        #1;
        chk("t1_wait_no_req", mem_req, 0);
        step();
        step();
        mem_resp = 2'b01; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_lack", arb_lack, 1);
        chk("t1_resp_not_yet", core_resp, 0);
        step();
        idle_inputs();
        #1;
        chk("t1_core_resp", core_resp, 8'h10);
        chk("t1_core_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("t1_lack_gone", arb_lack, 0);
        step();
        chk("t1_resp_cleared", core_resp, 0);
        chk("t1_rdata_cleared", core_rdata, 0);

        // grant 1 write, accept delayed 4 cycles
        arb_gnt = 3'd1; core_req = 4'b0010; mem_req_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_req_held", mem_req, 1);
            chk("t2_addr_stable", mem_addr, 32'h2004);
            chk("t2_wdata_stable", mem_wdata, 32'hCAFE_F00D);
            chk("t2_no_ack", arb_req_ack, 0);
            step();
        end
        mem_req_ack = 1'b1;
        #1;
        chk("t2_ack", arb_req_ack, 1);
        chk("t2_core_ack", core_req_ack, 4'b0010);
        chk("t2_cmd", mem_cmd, 1);
        chk("t2_width", mem_width, 2'b01);
        step();
        idle_inputs();
        #1;
        chk("t2_single_ack", arb_req_ack, 0);
        mem_resp = 2'b01;
        step();
        idle_inputs();
        #1;
        chk("t2_core_resp", core_resp, 8'h04);
        step();

        // grant 0 drops req before accept
        arb_gnt = 3'd0; core_req = 4'b0001;
        #1;
        chk("t3_req_up", mem_req, 1);
        step();
        core_req = 4'b0000; mem_req_ack = 1'b1;
        #1;
        chk("t3_req_dropped", mem_req, 0);
        chk("t3_no_ack", arb_req_ack, 0);
        chk("t3_no_core_ack", core_req_ack, 0);
        step();
        mem_req_ack = 1'b0; core_req = 4'b0001;
        #1;
        chk("t3_still_idle", mem_req, 1);
        chk("t3_no_lack", arb_lack, 0);
        step();
        idle_inputs();
        step();

        // grant 3 accepted, no response: timeout
        arb_gnt = 3'd3; core_req = 4'b1000; mem_req_ack = 1'b1;
        #1;
        chk("t4_ack", arb_req_ack, 1);
        early_lack = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            idle_inputs();
            #1;
            if (i < 200) begin
                if (arb_lack) early_lack++;
            end else begin
                chk("t4_early_lack", early_lack, 0);
                chk("t4_tmo_lack", arb_lack, 1);
            end
        end
        step();
        chk("t4_core_resp_err", core_resp, 8'h80);
        chk("t4_rdata_zero", core_rdata, 0);
        repeat (4) step();
        mem_resp = 2'b01; mem_rdata = 32'h5555_AAAA;
        #1;
        chk("t4_late_no_lack", arb_lack, 0);
        step();
        mem_resp = 2'b00;
        #1;
        chk("t4_late_no_resp", core_resp, 0);

        // error response for core 1, code 11 for core 0
        arb_gnt = 3'd1; core_req = 4'b0010; mem_req_ack = 1'b1;
        step();
        idle_inputs();
        mem_resp = 2'b10;
        #1;
        chk("t5_lack", arb_lack, 1);
        step();
        idle_inputs();
        #1;
        chk("t5_err_core1", core_resp, 8'h08);
        arb_gnt = 3'd0; core_req = 4'b0001; mem_req_ack = 1'b1;
        step();
        idle_inputs();
        mem_resp = 2'b11;
        step();
        idle_inputs();
        #1;
        chk("t5_code11_err", core_resp, 8'h02);
        step();

        // reset during wait, then a clean transaction
        arb_gnt = 3'd2; core_req = 4'b0100; mem_req_ack = 1'b1;
        step();
        #1;
        rstn = 1'b0;
        mem_resp = 2'b01;
        #1;
        chk("t6_rst_mem_req", mem_req, 0);
        chk("t6_rst_req_ack", arb_req_ack, 0);
        chk("t6_rst_lack", arb_lack, 0);
        chk("t6_rst_mem_addr", mem_addr, 0);
        step();
        idle_inputs();
        rstn = 1'b1;
        step();
        mem_resp = 2'b01; mem_rdata = 32'h7777_7777;
        #1;
        chk("t6_late_ignored", arb_lack, 0);
        step();
        idle_inputs();
        #1;
        chk("t6_no_resp", core_resp, 0);
        arb_gnt = 3'd0; core_req = 4'b0001; mem_req_ack = 1'b1;
        #1;
        chk("t6_after_ack", arb_req_ack, 1);
        step();
        idle_inputs();
        mem_resp = 2'b01; mem_rdata = 32'h1234_5678;
        step();
        idle_inputs();
        #1;
        chk("t6_after_resp", core_resp, 8'h01);
        chk("t6_after_rdata", core_rdata, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
